// File: rtl/ir_a2d_sequencer.sv
// IR emitter / A2D sequencer: settles each emitter pair, converts its left then right
// channel, and publishes the pair's readings; sweeps inner, mid and outer pairs in turn.
module ir_a2d_sequencer #(
  parameter int unsigned SETTLE_CYC = 4095,
  parameter int unsigned CNV_TMO    = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        IR_in_en,
  output logic        IR_mid_en,
  output logic        IR_out_en,
  output logic [11:0] lft_rd,
  output logic [11:0] rht_rd,
  output logic [1:0]  pair,
  output logic        rd_vld,
  output logic        sweep_done,
  output logic        tmo_err
);
  typedef enum logic [2:0] {IDLE, SETTLE, CNV_L, WAIT_L, CNV_R, WAIT_R, ADVANCE} state_t;

  localparam logic [11:0] SETTLE_LAST = 12'(SETTLE_CYC - 1);
  localparam logic [9:0]  TMO_LAST    = 10'(CNV_TMO - 1);

  state_t      state, nxt;
  logic [11:0] settle_cnt;
  logic [9:0]  tmo_cnt;
  logic [1:0]  idx;
  logic [11:0] lft_hold;
  logic        go_q;
  logic        waiting, tmo_hit, pair_done, emit;

  function automatic logic [2:0] chan_of(input logic [1:0] p, input logic right);
    case (p)
      2'd0:    chan_of = right ? 3'd0 : 3'd1;
      2'd1:    chan_of = right ? 3'd2 : 3'd4;
      default: chan_of = right ? 3'd7 : 3'd3;
    endcase
  endfunction

  always_comb begin
    nxt       = state;
    waiting   = (state == WAIT_L) || (state == WAIT_R);
    // tmo_cnt already counts the strt_cnv cycle, so this fires CNV_TMO cycles after it
    tmo_hit   = waiting && !cnv_cmplt && (tmo_cnt == TMO_LAST);
    pair_done = (state == WAIT_R) && cnv_cmplt;
    emit      = (state != IDLE) && (state != ADVANCE);
    strt_cnv  = (state == CNV_L) || (state == CNV_R);
    IR_in_en  = emit && (idx == 2'd0);
    IR_mid_en = emit && (idx == 2'd1);
    IR_out_en = emit && (idx == 2'd2);
    case (state)
      IDLE:    if (go) nxt = SETTLE;
      SETTLE: begin
        if (!go)                            nxt = IDLE;
        else if (settle_cnt == SETTLE_LAST) nxt = CNV_L;
      end
      CNV_L:   nxt = WAIT_L;
      WAIT_L: begin
        if (cnv_cmplt)    nxt = CNV_R;
        else if (tmo_hit) nxt = ADVANCE;
      end
      CNV_R:   nxt = WAIT_R;
      WAIT_R:  if (cnv_cmplt || tmo_hit) nxt = ADVANCE;
      ADVANCE: nxt = go ? SETTLE : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      idx        <= '0;
      lft_hold   <= '0;
      go_q       <= 1'b0;
      chnnl      <= '0;
      lft_rd     <= '0;
      rht_rd     <= '0;
      pair       <= '0;
      rd_vld     <= 1'b0;
      sweep_done <= 1'b0;
      tmo_err    <= 1'b0;
    end else begin
      state      <= nxt;
      go_q       <= go;
      settle_cnt <= (state == SETTLE && nxt == SETTLE) ? settle_cnt + 12'd1 : '0;

      if (strt_cnv)     tmo_cnt <= 10'd1;
      else if (waiting) tmo_cnt <= tmo_cnt + 10'd1;
      else              tmo_cnt <= '0;

      if (nxt == CNV_L)      chnnl <= chan_of(idx, 1'b0);
      else if (nxt == CNV_R) chnnl <= chan_of(idx, 1'b1);

      if (state == IDLE)         idx <= '0;
      else if (state == ADVANCE) idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;

      if (state == WAIT_L && cnv_cmplt) lft_hold <= res;

      rd_vld     <= pair_done;
      sweep_done <= pair_done && (idx == 2'd2);
      if (pair_done) begin
        lft_rd <= lft_hold;
        rht_rd <= res;
        pair   <= idx;
      end

      if (tmo_hit)                            tmo_err <= 1'b1;
      else if (state == IDLE && go && !go_q)  tmo_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ir_a2d_sequencer.sv
// Bench for ir_a2d_sequencer: ADC model with random latency/results and a reading
// scoreboard derived from the channel map, plus directed go-drop, timeout and reset cases.
`timescale 1ns/1ps
module tb_ir_a2d_sequencer;
  localparam int unsigned SETTLE = 16;
  localparam int unsigned TMO    = 32;

  logic        clk = 1'b0;
  logic        rst_n, go, strt_cnv, cnv_cmplt;
  logic [2:0]  chnnl;
  logic [11:0] res;
  logic        IR_in_en, IR_mid_en, IR_out_en;
  logic [11:0] lft_rd, rht_rd;
  logic [1:0]  pair;
  logic        rd_vld, sweep_done, tmo_err;

  ir_a2d_sequencer #(.SETTLE_CYC(SETTLE), .CNV_TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res), .IR_in_en(IR_in_en), .IR_mid_en(IR_mid_en),
    .IR_out_en(IR_out_en), .lft_rd(lft_rd), .rht_rd(rht_rd), .pair(pair),
    .rd_vld(rd_vld), .sweep_done(sweep_done), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned p; logic [11:0] lft; logic [11:0] rht; } rd_t;
  typedef struct { int unsigned lat; int unsigned p; logic [11:0] lft; logic [11:0] rht; bit sw; } vec_t;

  logic [2:0]  lch [3] = '{3'd1, 3'd4, 3'd3};
  logic [2:0]  rch [3] = '{3'd0, 3'd2, 3'd7};
  logic [2:0]  seq [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
  logic [11:0] left_val [3];
  rd_t         exp_q [$];
  vec_t        vecs [3];

  int unsigned passed = 0, total = 0, cyc = 0;
  int unsigned n_strt = 0, n_rd = 0, n_sweep = 0;
  int unsigned strt_cyc = 0, rd_cyc = 0, tmo_rise = 0, seq_ptr = 0;
  int unsigned lat_lo = 4, lat_hi = 4, adc_cnt = 0;
  int          withhold = -1;
  bit          adc_busy = 1'b0, rand_res = 1'b0, tmo_q = 1'b0;
  logic [2:0]  strt_ch = '0, adc_ch = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int unsigned pair_of(input logic [2:0] ch);
    for (int unsigned i = 0; i < 3; i++) if (ch == lch[i] || ch == rch[i]) return i;
    return 3;
  endfunction

  function automatic bit is_right(input logic [2:0] ch);
    for (int unsigned i = 0; i < 3; i++) if (ch == rch[i]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: sample outputs at the falling edge, run the ADC model, score readings.
  task automatic step();
    int unsigned p;
    rd_t e;
    @(negedge clk);
    cyc++;
    cnv_cmplt = 1'b0;
    if (strt_cnv) begin
      n_strt++;
      strt_cyc = cyc;
      strt_ch  = chnnl;
      chk("no_overlap", 32'(adc_busy), 32'd0);
      chk("chnnl_seq", 32'(chnnl), 32'(seq[seq_ptr % 6]));
      seq_ptr++;
      p = pair_of(chnnl);
      chk("ir_en_onehot", 32'({IR_out_en, IR_mid_en, IR_in_en}), 32'(3'd1 << p));
      adc_busy = 1'b1;
      adc_ch   = chnnl;
      adc_cnt  = $urandom_range(lat_hi, lat_lo);
    end else if (adc_busy) begin
      adc_cnt--;
      if (adc_cnt == 0) begin
        adc_busy = 1'b0;
        if (int'(adc_ch) != withhold) begin
          chk("chnnl_hold", 32'(chnnl), 32'(adc_ch));
          res       = rand_res ? 12'($urandom) : 12'(adc_ch) * 12'h111;
          cnv_cmplt = 1'b1;
          p = pair_of(adc_ch);
          if (p < 3) begin
            if (is_right(adc_ch)) begin
              e.p = p; e.lft = left_val[p]; e.rht = res;
              exp_q.push_back(e);
            end else left_val[p] = res;
          end
        end
      end
    end
    if (rd_vld) begin
      n_rd++;
      rd_cyc = cyc;
      if (sweep_done) n_sweep++;
      if (exp_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("pair", 32'(pair), 32'(e.p));
        chk("lft_rd", 32'(lft_rd), 32'(e.lft));
        chk("rht_rd", 32'(rht_rd), 32'(e.rht));
        chk("sweep_done", 32'(sweep_done), 32'(e.p == 2));
      end
    end else if (sweep_done) chk("sweep_alone", 32'(sweep_done), 32'd0);
    if (tmo_err && !tmo_q) tmo_rise = cyc;
    tmo_q = tmo_err;
  endtask

  task automatic wait_rd(input int unsigned target, input string name);
    int unsigned k = 0;
    while (n_rd < target && k < 3000) begin step(); k++; end
    chk(name, n_rd, target);
  endtask

  task automatic wait_strt(input logic [2:0] ch, input string name);
    int unsigned k = 0, b;
    bit hit = 1'b0;
    while (!hit && k < 3000) begin
      b = n_strt; step(); k++;
      hit = (n_strt != b) && (strt_ch == ch);
    end
    chk(name, 32'(hit), 32'd1);
  endtask

  task automatic wait_next_strt(input logic [2:0] ch, input string name);
    int unsigned k = 0, b = n_strt;
    while (n_strt == b && k < 3000) begin step(); k++; end
    chk(name, 32'(strt_ch), 32'(ch));
  endtask

  initial begin
    int unsigned prev, b_strt, b_rd, b_sw, t0, r0, k;
    rst_n = 1'b0; go = 1'b0; cnv_cmplt = 1'b0; res = '0;
    vecs[0] = '{lat: 3, p: 0, lft: 12'h111, rht: 12'h000, sw: 1'b0};
    vecs[1] = '{lat: 1, p: 1, lft: 12'h444, rht: 12'h222, sw: 1'b0};
    vecs[2] = '{lat: 7, p: 2, lft: 12'h333, rht: 12'h777, sw: 1'b1};

    step(); step();
    chk("rst_ctl", 32'({strt_cnv, chnnl, IR_in_en, IR_mid_en, IR_out_en, rd_vld, sweep_done, tmo_err}), 32'd0);
    chk("rst_rd", 32'({lft_rd, rht_rd, pair}), 32'd0);
    rst_n = 1'b1;
    step(); step();

    // Table-driven first sweep: fixed latency per pair, results ch*0x111.
    seq_ptr = 0; go = 1'b1; prev = cyc;
    for (int unsigned i = 0; i < 3; i++) begin
      lat_lo = vecs[i].lat; lat_hi = vecs[i].lat;
      wait_rd(n_rd + 1, "vec_rd");
      chk("vec_latency", rd_cyc - prev, SETTLE + 2 * (1 + vecs[i].lat) + 1);
      chk("vec_pair", 32'(pair), vecs[i].p);
      chk("vec_lft", 32'(lft_rd), 32'(vecs[i].lft));
      chk("vec_rht", 32'(rht_rd), 32'(vecs[i].rht));
      chk("vec_sweep", 32'(sweep_done), 32'(vecs[i].sw));
      prev = rd_cyc;
    end
    go = 1'b0; b_strt = n_strt;
    repeat (10) step();
    chk("idle_en", 32'({IR_in_en, IR_mid_en, IR_out_en}), 32'd0);
    chk("idle_no_strt", n_strt, b_strt);

    // Four randomized sweeps with go held high.
    rand_res = 1'b1; lat_lo = 1; lat_hi = 20; seq_ptr = 0;
    b_strt = n_strt; b_rd = n_rd; b_sw = n_sweep; k = 0;
    go = 1'b1;
    while (n_sweep < b_sw + 4 && k < 3000) begin step(); k++; end
    go = 1'b0;
    repeat (30) step();
    chk("sweeps_strt", n_strt - b_strt, 24);
    chk("sweeps_rd", n_rd - b_rd, 12);
    chk("sweeps_done", n_sweep - b_sw, 4);

    // go dropped one cycle after the ch4 conversion starts.
    rand_res = 1'b0; lat_lo = 5; lat_hi = 5; seq_ptr = 0;
    b_strt = n_strt; b_rd = n_rd; go = 1'b1;
    wait_strt(3'd4, "drop_strt_ch4");
    step(); go = 1'b0;
    wait_rd(b_rd + 2, "drop_rd");
    chk("drop_pair", 32'(pair), 32'd1);
    repeat (40) step();
    chk("drop_en", 32'({IR_in_en, IR_mid_en, IR_out_en}), 32'd0);
    chk("drop_strt_cnt", n_strt - b_strt, 4);
    chk("drop_last_ch", 32'(strt_ch), 32'd2);

    // ch0 conversion never completes.
    withhold = 0; seq_ptr = 0; b_rd = n_rd; go = 1'b1;
    wait_strt(3'd0, "tmo_strt_ch0");
    t0 = strt_cyc; k = 0;
    while (!tmo_err && k < 200) begin step(); k++; end
    chk("tmo_set", 32'(tmo_err), 32'd1);
    chk("tmo_delay", tmo_rise - t0, TMO);
    wait_next_strt(3'd4, "tmo_next_ch4");
    chk("tmo_no_rd", n_rd, b_rd);
    go = 1'b0; withhold = -1;
    wait_rd(b_rd + 1, "tmo_pair1_rd");
    repeat (5) step();
    chk("tmo_sticky", 32'(tmo_err), 32'd1);
    go = 1'b1; step();
    chk("tmo_clear", 32'(tmo_err), 32'd0);
    go = 1'b0;
    repeat (5) step();

    // Reset during WAIT_R of pair 2, then a spurious completion while settling.
    lat_lo = 10; lat_hi = 10; seq_ptr = 0; go = 1'b1;
    wait_strt(3'd7, "rst_strt_ch7");
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", 32'({strt_cnv, chnnl, IR_in_en, IR_mid_en, IR_out_en, rd_vld, sweep_done, tmo_err}), 32'd0);
    chk("rst_async_rd", 32'({lft_rd, rht_rd, pair}), 32'd0);
    adc_busy = 1'b0; exp_q.delete();
    step(); step();
    rst_n = 1'b1; r0 = cyc; seq_ptr = 0;
    repeat (5) step();
    cnv_cmplt = 1'b1; res = 12'hABC;
    step();
    chk("spur_lft", 32'(lft_rd), 32'd0);
    chk("spur_rht", 32'(rht_rd), 32'd0);
    wait_strt(3'd1, "rel_strt_ch1");
    chk("rel_strt_time", strt_cyc - r0, SETTLE + 1);
    wait_rd(n_rd + 1, "rel_rd");
    go = 1'b0;
    repeat (30) step();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ir_a2d_sequencer.md
IR_A2D_SEQUENCER -- requirements
Module: ir_a2d_sequencer

Interface
REQ-001 Parameter SETTLE_CYC, default 4095: clocks an IR emitter pair is enabled before its first conversion starts (legal 1..4095).
REQ-002 Parameter CNV_TMO, default 1023: clocks allowed from strt_cnv to cnv_cmplt before timeout (legal 16..1023).
REQ-003 clk  input  1  system clock, single clock domain; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 go  input  1  level; 1 = run sensor sweeps continuously.
REQ-006 strt_cnv  output  1  one-cycle pulse requesting an A2D conversion.
REQ-007 chnnl  output  3  A2D channel; held stable from strt_cnv until the matching cnv_cmplt.
REQ-008 cnv_cmplt  input  1  one-cycle pulse from the A2D SPI interface; res is valid in the same cycle.
REQ-009 res  input  12  A2D conversion result.
REQ-010 IR_in_en, IR_mid_en, IR_out_en  output  1 each  IR emitter pair enables; one-hot or all zero.
REQ-011 lft_rd, rht_rd  output  12 each  registered left/right readings of the last completed pair.
REQ-012 pair  output  2  pair index of lft_rd/rht_rd: 0 = inner, 1 = mid, 2 = outer.
REQ-013 rd_vld  output  1  one-cycle pulse; lft_rd, rht_rd and pair are all updated.
REQ-014 sweep_done  output  1  one-cycle pulse, coincident with the rd_vld of pair 2.
REQ-015 tmo_err  output  1  sticky flag, set on conversion timeout.

Function
REQ-016 States: IDLE, SETTLE, CNV_L, WAIT_L, CNV_R, WAIT_R, ADVANCE.
REQ-017 Channel map:
- pair 0: left ch1, right ch0.
- pair 1: left ch4, right ch2.
- pair 2: left ch3, right ch7.
REQ-018 IDLE: enables low, timer cleared, pair index 0. go=1 moves to SETTLE next cycle and sets the enable for the current pair.
REQ-019 SETTLE: 12-bit timer counts up from 0. On reaching SETTLE_CYC-1, go to CNV_L.
REQ-020 CNV_L: assert strt_cnv for exactly one cycle with chnnl set to the left channel, then go to WAIT_L. The timeout counter clears on strt_cnv.
REQ-021 WAIT_L: on cnv_cmplt, capture res into an internal left holding register, then go to CNV_R.
REQ-022 CNV_R and WAIT_R mirror CNV_L and WAIT_L on the right channel. On cnv_cmplt in WAIT_R, all of the following happen in the same edge:
- lft_rd <= held left value.
- rht_rd <= res.
- pair <= current index.
- rd_vld pulses the next cycle.
REQ-023 The emitter enable stays asserted for the whole pair (SETTLE through WAIT_R) and deasserts in ADVANCE.
REQ-024 ADVANCE, single cycle:
- Index increments, wrapping 2 -> 0.
- On wrap, sweep_done pulses together with the final rd_vld.
- Then SETTLE if go=1, else IDLE.
REQ-025 Minimum latency from go rising to the first rd_vld: 1 + SETTLE_CYC + 2*(1 + A2D conversion time) + 1 cycles.
REQ-026 go deasserted during SETTLE: return to IDLE next cycle; no conversion is issued.
REQ-027 go deasserted during CNV_*/WAIT_*: the conversion in flight is completed and the pair finishes (rd_vld is produced), then IDLE. SPI transfers are never abandoned.
REQ-028 cnv_cmplt outside WAIT_L/WAIT_R is ignored: no capture, no state change.
REQ-029 res is sampled only on the cnv_cmplt cycle; lft_rd and rht_rd hold their values otherwise.
REQ-030 Timeout in WAIT_*, i.e. CNV_TMO cycles with no cnv_cmplt:
- Set tmo_err.
- Discard the pair (no rd_vld).
- Go to ADVANCE.
REQ-031 tmo_err clears only on reset, or on a go 0->1 transition seen in IDLE.
REQ-032 At most one conversion is outstanding at any time; strt_cnv is never issued while in WAIT_*.

Reset
REQ-033 Asynchronous rst_n=0 forces, without a clock:
- State IDLE, pair index 0, timers 0.
- strt_cnv=0, chnnl=0, all IR enables 0.
- lft_rd=0, rht_rd=0, pair=0.
- rd_vld=0, sweep_done=0, tmo_err=0.
REQ-034 Reset mid-sweep drops emitters the same cycle. A cnv_cmplt arriving after reset release is ignored per REQ-028.

Verification
REQ-035 SETTLE_CYC=16, go=1, ADC model returns ch*0x111: rd_vld order is pair0 (lft 0x111, rht 0x000), pair1 (0x444, 0x222), pair2 (0x333, 0x777). sweep_done coincides with pair2. Exactly one IR enable is high per pair.
REQ-036 Hold go=1 for 4 sweeps: chnnl sequence is 1,0,4,2,3,7 repeated. Strt_cnv count = 24, rd_vld count = 12, sweep_done count = 4.
REQ-037 Drop go 1 cycle after strt_cnv on ch4: ch2 is still converted, rd_vld fires for pair1, then IDLE with enables 0. No further strt_cnv.
REQ-038 ADC model withholds cnv_cmplt on ch0, CNV_TMO=32: tmo_err sets 32 cycles after strt_cnv, no rd_vld for pair0, next strt_cnv on ch4. Toggling go 0->1 in IDLE clears tmo_err.
REQ-039 Assert rst_n=0 during WAIT_R of pair2: all outputs read 0 immediately. After release with go=1, the first strt_cnv is on ch1 after SETTLE_CYC cycles.
REQ-040 Inject a spurious cnv_cmplt in SETTLE with res=0xABC: lft_rd, rht_rd and state are unchanged.
